// File: rtl/vreq_burst_sched.sv
// Burst-aware round-robin scheduler: locks one downstream valid/ready port to a requester per burst.
// Optional stalled-owner timeout is compiled in with `define VREQ_SCHED_TIMEOUT_EN.
module vreq_burst_sched #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 64,
  parameter int BURST_MAX    = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_src,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(BURST_MAX - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  if (NUM_REQ < 2 || BURST_MAX < 1 || IDLE_TIMEOUT < 1) begin : g_bad_param
    $error("vreq_burst_sched: NUM_REQ>=2, BURST_MAX>=1 and IDLE_TIMEOUT>=1 are required");
  end

  logic [0:0]        state;
  logic [SRC_W-1:0]  owner;
  logic [SRC_W-1:0]  rr_ptr;
  logic [SRC_W-1:0]  pick;
  logic [SRC_W-1:0]  owner_next;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] owner_data;
  logic              pick_valid;
  logic              slot_free;
  logic              accept;
  logic              beat_last;
  logic              timeout_hit;
  logic              release_lock;

  // The output register can take a new beat when empty or draining this cycle.
  assign slot_free    = !out_valid || out_ready;
  assign accept       = (state == ST_LOCK) && slot_free && req_valid[owner];
  assign beat_last    = req_last[owner] || (beat_cnt == CAP_LAST);
  assign release_lock = (accept && beat_last) || timeout_hit;
  assign busy         = (state == ST_LOCK);
  assign owner_next   = (owner == SRC_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

  // Round-robin search: scanning offsets downward lets the closest set bit at/after rr_ptr win.
  always_comb begin
    logic [SRC_W-1:0] idx;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    pick       = '0;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == SRC_W'(i)) owner_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_LOCK && slot_free) req_ready[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      out_last  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= owner_data;
        out_src   <= owner;
        out_last  <= beat_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= ST_LOCK;
          end
        end
        default: begin
          if (accept) beat_cnt <= beat_cnt + 1'b1;
          if (release_lock) begin
            state  <= ST_IDLE;
            rr_ptr <= owner_next;
          end
        end
      endcase
    end
  end

`ifdef VREQ_SCHED_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;

  // Fires on the cycle whose idle increment would reach IDLE_TIMEOUT; the aborted burst gets no out_last.
  assign timeout_hit = (state == ST_LOCK) && !req_valid[owner] &&
                       (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (state != ST_LOCK || accept || timeout_hit) begin
      idle_cnt <= '0;
    end else if (!req_valid[owner]) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

endmodule
